// File: rtl/axis_tx_pkg.sv
// Shared types and constants for the AXI-Stream frame transmitter.
package axis_tx_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int DEF_LEN_WIDTH = 16;

  // PRBS31 = x^31 + x^28 + 1, taps given as 0-based state bit indices
  localparam int PRBS_ORDER = 31;
  localparam int PRBS_TAP_A = 30;
  localparam int PRBS_TAP_B = 27;

endpackage

// File: rtl/axis_frame_tx_if.sv
// AXI-Stream handshake bundle between the transmitter and downstream blocks.
interface axis_frame_tx_if #(parameter int DATA_WIDTH = 32);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/axis_tx_prbs.sv
// Combinational DATA_WIDTH-step PRBS31 advance; only built with AXIS_TX_PRBS_EN.
`ifdef AXIS_TX_PRBS_EN
module axis_tx_prbs
  import axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [PRBS_ORDER-1:0] state_in,
  output logic [PRBS_ORDER-1:0] state_out,
  output logic [DATA_WIDTH-1:0] word
);

  // first generated bit lands in the word MSB
  always_comb begin
    logic [PRBS_ORDER-1:0] s;
    logic                  nb;
    s    = state_in;
    nb   = 1'b0;
    word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      nb = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
      s  = {s[PRBS_ORDER-2:0], nb};
      word[DATA_WIDTH-1-i] = nb;
    end
    state_out = s;
  end

endmodule
`endif

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter: counter (or, with AXIS_TX_PRBS_EN, PRBS31) frames on start.
module axis_frame_tx
  import axis_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [7:0]            frames,
  input  logic [DATA_WIDTH-1:0] seed,
`ifdef AXIS_TX_PRBS_EN
  input  logic                  pattern_sel,
`endif
  output logic                  busy,
  output logic                  done,
  axis_frame_tx_if.master       m_axis
);

  localparam logic [DATA_WIDTH-1:0] ONE_D = 1;
  localparam logic [LEN_WIDTH-1:0]  ONE_L = 1;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_q, beat_cnt;
  logic [7:0]            frames_q, frame_cnt;
  logic                  stop_req;
  logic                  valid_q, last_q;
  logic [DATA_WIDTH-1:0] data_q, next_data, first_data;
  logic                  start_ok, accept, tx_end;

  assign m_axis.valid = valid_q;
  assign m_axis.last  = last_q;
  assign m_axis.data  = data_q;

  assign start_ok = (state == IDLE) && start && (frame_len != '0);
  assign accept   = valid_q && m_axis.ready;
  // a stop arriving on the closing beat's edge still ends the transmission
  assign tx_end   = accept && last_q &&
                    (((frames_q != 8'd0) && (frame_cnt == frames_q - 8'd1)) || stop_req || stop);

`ifdef AXIS_TX_PRBS_EN
  logic                  pat_q;
  logic [PRBS_ORDER-1:0] lfsr_q, prbs_in, prbs_state;
  logic [DATA_WIDTH-1:0] prbs_word;

  // in IDLE the generator runs from the seed so the first word is ready at start
  assign prbs_in = (state == IDLE) ?
                   ((seed[PRBS_ORDER-1:0] == '0) ? {{(PRBS_ORDER-1){1'b0}}, 1'b1} : seed[PRBS_ORDER-1:0]) :
                   lfsr_q;

  axis_tx_prbs #(.DATA_WIDTH(DATA_WIDTH)) u_prbs (
    .state_in  (prbs_in),
    .state_out (prbs_state),
    .word      (prbs_word)
  );

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      pat_q  <= 1'b0;
      lfsr_q <= '0;
    end else if (start_ok) begin
      pat_q  <= pattern_sel;
      lfsr_q <= prbs_state;
    end else if (accept) begin
      lfsr_q <= prbs_state;
    end
  end

  assign next_data  = pat_q ? prbs_word : data_q + ONE_D;
  assign first_data = pattern_sel ? prbs_word : seed;
`else
  assign next_data  = data_q + ONE_D;
  assign first_data = seed;
`endif

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      frames_q  <= '0;
      frame_cnt <= '0;
      stop_req  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= SEND;
            busy      <= 1'b1;
            valid_q   <= 1'b1;
            last_q    <= (frame_len == ONE_L);
            data_q    <= first_data;
            len_q     <= frame_len;
            frames_q  <= frames;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            stop_req  <= 1'b0;
          end
        end
        SEND: begin
          if (stop) stop_req <= 1'b1;
          if (accept) begin
            data_q <= next_data;
            if (last_q) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              last_q    <= (len_q == ONE_L);
              if (tx_end) begin
                state    <= IDLE;
                busy     <= 1'b0;
                valid_q  <= 1'b0;
                last_q   <= 1'b0;
                done     <= 1'b1;
                stop_req <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + ONE_L;
              last_q   <= ((beat_cnt + ONE_L) == (len_q - ONE_L));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx; the PRBS step runs only with AXIS_TX_PRBS_EN.
module tb_axis_frame_tx;

  logic        axi_clk = 1'b0;
  logic        axi_reset, start, stop;
  logic [15:0] frame_len;
  logic [7:0]  frames;
  logic [31:0] seed;
  logic        busy, done;
`ifdef AXIS_TX_PRBS_EN
  logic        pattern_sel;
`endif
  int checks = 0;
  int errors = 0;

  axis_frame_tx_if #(.DATA_WIDTH(32)) m_axis ();

  axis_frame_tx #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .axi_clk   (axi_clk),
    .axi_reset (axi_reset),
    .start     (start),
    .stop      (stop),
    .frame_len (frame_len),
    .frames    (frames),
    .seed      (seed),
`ifdef AXIS_TX_PRBS_EN
    .pattern_sel (pattern_sel),
`endif
    .busy      (busy),
    .done      (done),
    .m_axis    (m_axis.master)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // reference PRBS31: one bit per step, shifted into the word from the LSB side
  function automatic logic [31:0] ref_prbs(inout logic [30:0] s);
    logic [31:0] w;
    logic        b;
    w = 32'd0;
    for (int i = 0; i < 32; i++) begin
      b = s[30] ^ s[27];
      s = {s[29:0], b};
      w = {w[30:0], b};
    end
    return w;
  endfunction

  initial begin
    int k, cyc;
    axi_reset = 1'b1; start = 1'b0; stop = 1'b0;
    frame_len = 16'd0; frames = 8'd0; seed = 32'd0;
    m_axis.ready = 1'b0;
`ifdef AXIS_TX_PRBS_EN
    pattern_sel = 1'b0;
`endif
    tick(); tick();
    chk1("rst_valid", m_axis.valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_last", m_axis.last, 1'b0);
    chk32("rst_data", m_axis.data, 32'd0);
    axi_reset = 1'b0;
    tick();

    // single frame of 4 beats, ready held high
    frame_len = 16'd4; frames = 8'd1; seed = 32'h10; m_axis.ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("t1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("t1_valid", m_axis.valid, 1'b1);
      chk32("t1_data", m_axis.data, 32'h10 + 32'(i));
      chk1("t1_last", m_axis.last, i == 3);
      tick();
    end
    chk1("t1_done", done, 1'b1);
    chk1("t1_valid_end", m_axis.valid, 1'b0);
    chk1("t1_busy_end", busy, 1'b0);
    tick();
    chk1("t1_done_pulse", done, 1'b0);

    // two frames of 3 under random backpressure
    frame_len = 16'd3; frames = 8'd2; seed = 32'h100; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < 6 && cyc < 200) begin
      m_axis.ready = 1'($urandom_range(0, 1));
      chk1("t2_valid", m_axis.valid, 1'b1);
      chk32("t2_data", m_axis.data, 32'h100 + 32'(k));
      chk1("t2_last", m_axis.last, (k % 3) == 2);
      if (m_axis.ready) k++;
      cyc++;
      tick();
    end
    chk32("t2_beats", 32'(k), 32'd6);
    chk1("t2_done", done, 1'b1);
    chk1("t2_busy_end", busy, 1'b0);
    m_axis.ready = 1'b1;
    tick();

    // continuous mode, stop on beat 7 ends after beat 10
    frame_len = 16'd5; frames = 8'd0; seed = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      chk32("t3_data", m_axis.data, 32'(n - 1));
      chk1("t3_last", m_axis.last, (n % 5) == 0);
      stop = (n == 7);
      tick();
    end
    stop = 1'b0;
    chk1("t3_done", done, 1'b1);
    chk1("t3_valid_end", m_axis.valid, 1'b0);

    // start in the done cycle; data wraps modulo 2^32
    frame_len = 16'd3; frames = 8'd1; seed = 32'hFFFF_FFFE; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("t4_busy", busy, 1'b1);
    chk32("t4_d0", m_axis.data, 32'hFFFF_FFFE);
    tick();
    chk32("t4_d1", m_axis.data, 32'hFFFF_FFFF);
    tick();
    chk32("t4_d2", m_axis.data, 32'h0000_0000);
    chk1("t4_last", m_axis.last, 1'b1);
    tick();
    chk1("t4_done", done, 1'b1);
    tick();

    // reset mid-frame, zero-length start ignored, then normal restart
    frame_len = 16'd4; frames = 8'd1; seed = 32'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk32("t5_mid_data", m_axis.data, 32'h21);
    axi_reset = 1'b1;
    tick();
    axi_reset = 1'b0;
    chk1("t5_rst_valid", m_axis.valid, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_last", m_axis.last, 1'b0);
    frame_len = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk1("t5_zero_busy", busy, 1'b0);
    chk1("t5_zero_valid", m_axis.valid, 1'b0);
    tick();
    chk1("t5_zero_done", done, 1'b0);
    frame_len = 16'd2; frames = 8'd1; seed = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    chk32("t5_d0", m_axis.data, 32'h55);
    chk1("t5_l0", m_axis.last, 1'b0);
    tick();
    chk32("t5_d1", m_axis.data, 32'h56);
    chk1("t5_l1", m_axis.last, 1'b1);
    tick();
    chk1("t5_done", done, 1'b1);
    tick();

`ifdef AXIS_TX_PRBS_EN
    begin
      logic [30:0] s;
      s = 31'd1;
      frame_len = 16'd3; frames = 8'd1; seed = 32'd0; pattern_sel = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; pattern_sel = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk32("t6_prbs", m_axis.data, ref_prbs(s));
        tick();
      end
      chk1("t6_done", done, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
